decoder_scan_sequencer: RTL

- Upstream driver for the 3-to-8 one-hot decoder stage.
- Steps a 3-bit select (A,B,C) and an enable through the channels set in a mask.
- Holds each channel enabled for a programmable dwell time, then inserts a blanking gap.
- Used for scanned display digits and channel strobing; outputs connect directly to the decoder's A,B,C,en inputs.

---
 rtl/scan_pkg.sv | 30 +++
 rtl/scan_next_chan.sv | 40 ++++
 rtl/decoder_scan_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the decoder scan sequencer.
//   state_t  : sequencer states (IDLE, ACTIVE, GAP)
//   NUM_CH   : number of decoder channels (fixed at 8)
//   SEL_W    : select width (3 bits: A,B,C)
//   chan_t   : channel index type
//   lowest_set() : index of the lowest set bit of a channel mask
package scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] chan_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Returns 0 for an empty mask; callers check emptiness separately.
  function automatic chan_t lowest_set(input logic [NUM_CH-1:0] mask);
    chan_t idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = i[SEL_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_next_chan.sv
// Combinational channel finder for the scan sequencer.
// Ports:
//   mask     in  [NUM_CH-1:0]  channel mask to search
//   cur      in  chan_t        current channel index
//   next_idx out chan_t        next set bit above cur, wrapping to the lowest
//   wrap     out               no set bit above cur (next_idx wrapped)
//   lowest   out chan_t        lowest set bit of mask
//   empty    out               mask has no bits set
module scan_next_chan
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  chan_t             cur,
  output chan_t             next_idx,
  output logic              wrap,
  output chan_t             lowest,
  output logic              empty
);

  chan_t above_idx;
  logic  found_above;

  // Searching downward lets the last hit win, giving the lowest qualifying bit.
  always_comb begin
    above_idx   = '0;
    found_above = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        above_idx   = i[SEL_W-1:0];
        found_above = 1'b1;
      end
    end
  end

  assign lowest   = lowest_set(mask);
  assign empty    = (mask == '0);
  assign wrap     = !found_above;
  assign next_idx = found_above ? above_idx : lowest;

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving a 3-to-8 one-hot decoder (A,B,C,en).
// Steps through the channels set in chan_mask, holding each enabled for
// max(dwell,1) cycles. Mask and dwell are latched only at frame boundaries.
// Build option SCAN_GAP_EN: when defined, a one-cycle blanking GAP state
// (en low, select held) is inserted between channels; when undefined the
// enable stays high across channel changes.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   start        1-cycle scan request, honoured only in IDLE
//   stop         end scanning after the current dwell (level or pulse)
//   dwell        enabled cycles per channel (0 behaves as 1)
//   chan_mask    bit i set = channel i is scanned
//   sel_a/b/c    registered select, A = MSB
//   sel_en       registered decoder enable
//   busy         high whenever not IDLE
//   frame_done   1-cycle pulse after the last channel of a frame finishes
module decoder_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int NUM_CH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  chan_mask,
  output logic               sel_a,
  output logic               sel_b,
  output logic               sel_c,
  output logic               sel_en,
  output logic               busy,
  output logic               frame_done
);

  state_t             state, state_d;
  chan_t              sel_q, sel_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic               stop_pending, stop_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               fd_q, fd_d;
  logic               advance;

  logic [NUM_CH-1:0]  find_mask;
  chan_t              next_idx;
  chan_t              lowest;
  logic               wrap;
  logic               mask_empty;

  // Counter load value: a dwell of 0 is treated as 1 cycle.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  // In IDLE the finder looks at the live mask to pick the first channel;
  // otherwise it walks the mask latched for the current frame.
  assign find_mask = (state == IDLE) ? chan_mask : mask_q;

  scan_next_chan u_next (
    .mask     (find_mask),
    .cur      (sel_q),
    .next_idx (next_idx),
    .wrap     (wrap),
    .lowest   (lowest),
    .empty    (mask_empty)
  );

  // Next-state and next-output logic. Outputs are computed here and
  // registered below, so nothing from an input reaches a pin combinationally.
  always_comb begin
    state_d = state;
    sel_d   = sel_q;
    cnt_d   = cnt;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    stop_d  = stop_pending;
    en_d    = 1'b0;
    fd_d    = 1'b0;
    advance = 1'b0;

    case (state)
      IDLE: begin
        if (start && !mask_empty) begin
          state_d = ACTIVE;
          mask_d  = chan_mask;
          dwell_d = dwell;
          sel_d   = lowest;
          cnt_d   = dwell_load(dwell);
          en_d    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
          en_d  = 1'b1;
        end else begin
          // wrap means no channel above this one: it closes the frame.
          fd_d = wrap;
`ifdef SCAN_GAP_EN
          state_d = GAP;
`else
          advance = 1'b1;
`endif
        end
      end
`ifdef SCAN_GAP_EN
      GAP: advance = 1'b1;
`endif
      default: state_d = IDLE;
    endcase

    if ((state != IDLE) && stop) stop_d = 1'b1;

    // Move on to the next channel; a wrap starts a new frame, so the
    // live mask and dwell are re-latched before choosing the channel.
    if (advance) begin
      if (stop_pending || stop) begin
        state_d = IDLE;
      end else if (wrap) begin
        mask_d  = chan_mask;
        dwell_d = dwell;
        if (chan_mask == '0) begin
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
          sel_d   = lowest_set(chan_mask);
          cnt_d   = dwell_load(dwell);
          en_d    = 1'b1;
        end
      end else begin
        state_d = ACTIVE;
        sel_d   = next_idx;
        cnt_d   = dwell_load(dwell_q);
        en_d    = 1'b1;
      end
    end

    // Start beats a simultaneous stop, and no stop survives into IDLE.
    if (state_d == IDLE) stop_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset clears the decoder drive at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel_q        <= '0;
      cnt          <= '0;
      dwell_q      <= '0;
      mask_q       <= '0;
      stop_pending <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      fd_q         <= 1'b0;
    end else begin
      state        <= state_d;
      sel_q        <= sel_d;
      cnt          <= cnt_d;
      dwell_q      <= dwell_d;
      mask_q       <= mask_d;
      stop_pending <= stop_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      fd_q         <= fd_d;
    end
  end

  assign sel_a      = sel_q[2];
  assign sel_b      = sel_q[1];
  assign sel_c      = sel_q[0];
  assign sel_en     = en_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule
